// File: rtl/fpc_pkg.sv
// fpc_pkg: shared constants and helpers for the frame position counter.
//   FPC_COLS   - default columns per row
//   FPC_ROWS   - default rows per frame
//   FPC_MF_LEN - default frames per multiframe
//   clog2()    - counter width for a modulus, never narrower than 1 bit
package fpc_pkg;

  localparam int FPC_COLS   = 1041;
  localparam int FPC_ROWS   = 4;
  localparam int FPC_MF_LEN = 256;

  // Width needed to hold 0..value-1; a modulus of 1 still gets a 1-bit counter
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/fpc_wrap_cnt.sv
// fpc_wrap_cnt: modulus/step counter used as one stage of the position chain.
//   clk  - clock
//   rst  - asynchronous active-high reset, clears cnt
//   en   - advance by STEP this cycle
//   clr  - treat the current value as 0 (alignment); loads 0 when not advancing
//   cnt  - registered count, 0..MOD-1 in steps of STEP
//   wrap - combinational: advancing this cycle from the terminal value MOD-STEP
module fpc_wrap_cnt #(
  parameter int MOD  = 2,
  parameter int STEP = 1,
  parameter int W    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST   = W'(MOD - STEP);
  localparam logic [W-1:0] STEP_W = W'(STEP);

  logic [W-1:0] cnt_e;

  // Effective value: an alignment pulse makes the current position zero
  assign cnt_e = clr ? '0 : cnt;

  // Terminal value is compared explicitly so non-power-of-two moduli wrap correctly
  assign wrap = en & (cnt_e == LAST);

  // Advance from the effective value; an alignment without a beat just zeroes the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt_e + STEP_W;
    end else if (clr) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/fpc_gen.sv
// fpc_gen: frame position counter for the framed datapath.
//   i_clk     - clock
//   i_rst     - asynchronous active-high reset
//   i_valid   - a beat of STEP columns is present this cycle
//   i_sync    - current beat (or next beat if idle) is column 0, row 0, multiframe 0
//   o_col_cnt - registered column of the next beat
//   o_row_cnt - registered row of the next beat
//   o_mf_cnt  - registered multiframe index of the next beat
//   o_sof     - current beat is column 0, row 0
//   o_eor     - current beat contains the last column of a row
//   o_eof     - current beat contains the last column of the last row
//   o_locked  - an alignment pulse has been seen since reset
module fpc_gen
  import fpc_pkg::*;
#(
  parameter int COLS   = FPC_COLS,
  parameter int ROWS   = FPC_ROWS,
  parameter int STEP   = 1,
  parameter int MF_LEN = FPC_MF_LEN
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic                      i_sync,
  output logic [clog2(COLS)-1:0]    o_col_cnt,
  output logic [clog2(ROWS)-1:0]    o_row_cnt,
  output logic [clog2(MF_LEN)-1:0]  o_mf_cnt,
  output logic                      o_sof,
  output logic                      o_eor,
  output logic                      o_eof,
  output logic                      o_locked
);

  localparam int CW = clog2(COLS);
  localparam int RW = clog2(ROWS);
  localparam int MW = clog2(MF_LEN);

  // A beat must never straddle a row boundary
  if ((STEP < 1) || ((COLS % STEP) != 0)) begin : g_bad_step
    $error("fpc_gen: COLS must be a positive multiple of STEP");
  end

  logic          col_wrap;
  logic          row_wrap;
  logic          mf_wrap_unused;
  logic [CW-1:0] col_e;
  logic [RW-1:0] row_e;

  // Column advances on every beat; each stage enables the next on its wrap
  fpc_wrap_cnt #(.MOD(COLS), .STEP(STEP), .W(CW)) u_col (
    .clk  (i_clk),
    .rst  (i_rst),
    .en   (i_valid),
    .clr  (i_sync),
    .cnt  (o_col_cnt),
    .wrap (col_wrap)
  );

  fpc_wrap_cnt #(.MOD(ROWS), .STEP(1), .W(RW)) u_row (
    .clk  (i_clk),
    .rst  (i_rst),
    .en   (col_wrap),
    .clr  (i_sync),
    .cnt  (o_row_cnt),
    .wrap (row_wrap)
  );

  fpc_wrap_cnt #(.MOD(MF_LEN), .STEP(1), .W(MW)) u_mf (
    .clk  (i_clk),
    .rst  (i_rst),
    .en   (row_wrap),
    .clr  (i_sync),
    .cnt  (o_mf_cnt),
    .wrap (mf_wrap_unused)
  );

  assign col_e = i_sync ? '0 : o_col_cnt;
  assign row_e = i_sync ? '0 : o_row_cnt;

  // Column wrap is exactly "valid beat at COLS-STEP"; row wrap adds "last row"
  assign o_sof = i_valid & (col_e == '0) & (row_e == '0);
  assign o_eor = col_wrap;
  assign o_eof = row_wrap;

  // Sticky lock flag, only reset clears it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_locked <= 1'b0;
    end else if (i_sync) begin
      o_locked <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpc_gen.sv
// tb_fpc_gen: randomized and directed bench for fpc_gen against a beat-index model.
// Three instances: A default parameters, B (16,2,STEP 4,MF 3), C (4,2,1,MF 4).
module tb_fpc_gen;

  localparam int A_COLS = 1041, A_ROWS = 4, A_STEP = 1, A_MF = 256;
  localparam int B_COLS = 16,   B_ROWS = 2, B_STEP = 4, B_MF = 3;
  localparam int C_COLS = 4,    C_ROWS = 2, C_STEP = 1, C_MF = 4;

  logic i_clk;
  logic clk_en;
  logic i_rst;
  logic va, sa, vb, sb, vc, sc;

  logic [10:0] col_a;
  logic [1:0]  row_a;
  logic [7:0]  mf_a;
  logic        sof_a, eor_a, eof_a, lock_a;
  logic [3:0]  col_b;
  logic [0:0]  row_b;
  logic [1:0]  mf_b;
  logic        sof_b, eor_b, eof_b, lock_b;
  logic [1:0]  col_c;
  logic [0:0]  row_c;
  logic [1:0]  mf_c;
  logic        sof_c, eor_c, eof_c, lock_c;

  int assertCount;
  int failCount;

  // Model state: valid beats since the last alignment, and the lock flag
  int na, nb, nc;
  bit la, lb, lc;

  bit trackA;
  int beatA, eorCountA, eofBeatA;
  int seqB[5];

  fpc_gen #(.COLS(A_COLS), .ROWS(A_ROWS), .STEP(A_STEP), .MF_LEN(A_MF)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(va), .i_sync(sa),
    .o_col_cnt(col_a), .o_row_cnt(row_a), .o_mf_cnt(mf_a),
    .o_sof(sof_a), .o_eor(eor_a), .o_eof(eof_a), .o_locked(lock_a)
  );

  fpc_gen #(.COLS(B_COLS), .ROWS(B_ROWS), .STEP(B_STEP), .MF_LEN(B_MF)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(vb), .i_sync(sb),
    .o_col_cnt(col_b), .o_row_cnt(row_b), .o_mf_cnt(mf_b),
    .o_sof(sof_b), .o_eor(eor_b), .o_eof(eof_b), .o_locked(lock_b)
  );

  fpc_gen #(.COLS(C_COLS), .ROWS(C_ROWS), .STEP(C_STEP), .MF_LEN(C_MF)) dut_c (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(vc), .i_sync(sc),
    .o_col_cnt(col_c), .o_row_cnt(row_c), .o_mf_cnt(mf_c),
    .o_sof(sof_c), .o_eor(eor_c), .o_eof(eof_c), .o_locked(lock_c)
  );

  // Gated clock so the reset-with-stopped-clock case can be exercised
  always begin
    #5;
    if (clk_en) i_clk = ~i_clk;
  end

  // Position of beat n in a linear column stream
  function automatic int posCol(int n, int cols, int step);
    return (n * step) % cols;
  endfunction

  function automatic int posRow(int n, int cols, int rows, int step);
    return ((n * step) / cols) % rows;
  endfunction

  function automatic int posMf(int n, int cols, int rows, int step, int mfl);
    return ((n * step) / (cols * rows)) % mfl;
  endfunction

  function automatic int nextN(int n, bit v, bit s, int period);
    int ne;
    ne = s ? 0 : n;
    if (v) return (ne + 1) % period;
    if (s) return 0;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkDut(input string p, input int n, input bit lk, input bit v, input bit s,
                          input int cols, input int rows, input int step, input int mfl,
                          input int oc, input int orow, input int omf,
                          input int osof, input int oeor, input int oeof, input int olk);
    int ne, ce, re, eor;
    checkOutput({p, "_col"}, oc, posCol(n, cols, step));
    checkOutput({p, "_row"}, orow, posRow(n, cols, rows, step));
    checkOutput({p, "_mf"}, omf, posMf(n, cols, rows, step, mfl));
    ne = s ? 0 : n;
    ce = posCol(ne, cols, step);
    re = posRow(ne, cols, rows, step);
    eor = (v && ce == cols - step) ? 1 : 0;
    checkOutput({p, "_sof"}, osof, (v && ce == 0 && re == 0) ? 1 : 0);
    checkOutput({p, "_eor"}, oeor, eor);
    checkOutput({p, "_eof"}, oeof, (eor == 1 && re == rows - 1) ? 1 : 0);
    checkOutput({p, "_locked"}, olk, lk ? 1 : 0);
  endtask

  task automatic checkAll();
    checkDut("a", na, la, va, sa, A_COLS, A_ROWS, A_STEP, A_MF,
             int'(col_a), int'(row_a), int'(mf_a), int'(sof_a), int'(eor_a), int'(eof_a), int'(lock_a));
    checkDut("b", nb, lb, vb, sb, B_COLS, B_ROWS, B_STEP, B_MF,
             int'(col_b), int'(row_b), int'(mf_b), int'(sof_b), int'(eor_b), int'(eof_b), int'(lock_b));
    checkDut("c", nc, lc, vc, sc, C_COLS, C_ROWS, C_STEP, C_MF,
             int'(col_c), int'(row_c), int'(mf_c), int'(sof_c), int'(eor_c), int'(eof_c), int'(lock_c));
  endtask

  task automatic resetModels();
    na = 0; nb = 0; nc = 0;
    la = 0; lb = 0; lc = 0;
  endtask

  task automatic updateModels();
    if (i_rst) begin
      resetModels();
    end else begin
      na = nextN(na, va, sa, (A_COLS / A_STEP) * A_ROWS * A_MF);
      nb = nextN(nb, vb, sb, (B_COLS / B_STEP) * B_ROWS * B_MF);
      nc = nextN(nc, vc, sc, (C_COLS / C_STEP) * C_ROWS * C_MF);
      la = la | sa;
      lb = lb | sb;
      lc = lc | sc;
    end
  endtask

  // Called just after a rising edge: drive, check at the falling edge, advance the model
  task automatic applyStimulus(input bit a_v, input bit a_s, input bit b_v, input bit b_s,
                               input bit c_v, input bit c_s);
    va = a_v; sa = a_s; vb = b_v; sb = b_s; vc = c_v; sc = c_s;
    @(negedge i_clk);
    checkAll();
    if (trackA && eor_a === 1'b1) begin
      eorCountA++;
      checkOutput("a_eor_spacing", beatA % A_COLS, A_COLS - 1);
    end
    if (trackA && eof_a === 1'b1) eofBeatA = beatA;
    @(posedge i_clk);
    updateModels();
    if (trackA && va) beatA++;
    #1;
  endtask

  task automatic randomCycle(input bit withA);
    bit a_v, a_s;
    a_v = withA ? 1'($urandom_range(0, 1)) : 1'b0;
    a_s = withA ? ($urandom_range(0, 39) == 0) : 1'b0;
    applyStimulus(a_v, a_s,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
  endtask

  initial begin
    assertCount = 0;
    failCount = 0;
    trackA = 0;
    beatA = 0;
    eorCountA = 0;
    eofBeatA = -1;
    seqB = '{0, 4, 8, 12, 0};
    resetModels();
    i_clk = 0;
    clk_en = 1;
    i_rst = 1;
    va = 0; sa = 0; vb = 0; sb = 0; vc = 0; sc = 0;
    #1;

    // Reset: counts zero, sof follows i_valid
    applyStimulus(1, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    i_rst = 0;

    // A: one full multiframe row set of continuous beats; B and C run random traffic
    trackA = 1;
    for (int k = 0; k < 4 * A_COLS; k++) begin
      applyStimulus(1, 0, 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
    end
    trackA = 0;
    checkOutput("a_eor_count", eorCountA, 4);
    checkOutput("a_eof_beat", eofBeatA, 4 * A_COLS - 1);
    checkOutput("a_frame_col", int'(col_a), 0);
    checkOutput("a_frame_row", int'(row_a), 0);
    checkOutput("a_frame_mf", int'(mf_a), 1);

    // B: align, then one beat in three
    applyStimulus(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 15; k++) begin
      if (k % 3 == 0) begin
        checkOutput("b_col_seq", int'(col_b), seqB[k / 3]);
        vb = 1;
        #1;
        checkOutput("b_eor_at12", int'(eor_b), (k / 3 == 3) ? 1 : 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
      end else begin
        applyStimulus(0, 0, 0, 0, 0, 0);
      end
    end

    // A: mid-frame sync with a beat at column 7, row 1
    for (int k = 0; k < A_COLS + 7; k++) applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("a_pre_col", int'(col_a), 7);
    checkOutput("a_pre_row", int'(row_a), 1);
    checkOutput("a_pre_locked", int'(lock_a), 0);
    va = 1; sa = 1;
    #1;
    checkOutput("a_sync_sof", int'(sof_a), 1);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("a_sync_col", int'(col_a), 1);
    checkOutput("a_sync_row", int'(row_a), 0);
    checkOutput("a_sync_mf", int'(mf_a), 0);
    checkOutput("a_locked_rise", int'(lock_a), 1);

    // A: sync on an idle cycle at column 5
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("a_idle_pre_col", int'(col_a), 5);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("a_idle_sync_col", int'(col_a), 0);
    checkOutput("a_idle_sync_row", int'(row_a), 0);
    checkOutput("a_idle_sync_mf", int'(mf_a), 0);
    va = 1; sa = 0;
    #1;
    checkOutput("a_idle_next_sof", int'(sof_a), 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("a_locked_hold", int'(lock_a), 1);

    // C: full multiframe, mf wraps 3 -> 0 on the eof beat
    applyStimulus(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 31; k++) applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("c_last_mf", int'(mf_c), C_MF - 1);
    vc = 1;
    #1;
    checkOutput("c_last_eof", int'(eof_c), 1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("c_wrap_col", int'(col_c), 0);
    checkOutput("c_wrap_row", int'(row_c), 0);
    checkOutput("c_wrap_mf", int'(mf_c), 0);

    // C: sync exactly at the natural wrap point changes nothing
    vc = 1; sc = 1;
    #1;
    checkOutput("c_natsync_sof", int'(sof_c), 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("c_natsync_col", int'(col_c), 1);
    checkOutput("c_natsync_row", int'(row_c), 0);
    checkOutput("c_natsync_mf", int'(mf_c), 0);

    // Async reset mid-frame with the clock stopped
    for (int k = 0; k < 9; k++) applyStimulus(1, 0, 1, 0, 1, 0);
    va = 0; vb = 0; vc = 0;
    @(negedge i_clk);
    clk_en = 0;
    #2;
    i_rst = 1;
    va = 1;
    #1;
    checkOutput("rst_col_a", int'(col_a), 0);
    checkOutput("rst_row_a", int'(row_a), 0);
    checkOutput("rst_mf_a", int'(mf_a), 0);
    checkOutput("rst_locked_a", int'(lock_a), 0);
    checkOutput("rst_sof_a", int'(sof_a), 1);
    checkOutput("rst_col_c", int'(col_c), 0);
    checkOutput("rst_locked_c", int'(lock_c), 0);
    resetModels();
    #4;
    i_rst = 0;
    va = 0;
    clk_en = 1;
    @(posedge i_clk);
    #1;
    va = 1;
    #1;
    checkOutput("post_rst_sof_a", int'(sof_a), 1);
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Free random traffic on all three instances
    for (int k = 0; k < 400; k++) randomCycle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fpc_gen.md
# fpc_gen

Parametrised frame position counter, successor to the fixed 1041-column counter. It tracks the column, row and multiframe position of every valid beat in the framed datapath, and accepts multi-column beats. It re-aligns on a frame-sync pulse and emits start-of-frame, end-of-row and end-of-frame strobes. It sits beside the framer/deframer datapath, and downstream overhead insert/extract logic keys off its outputs.

## Interface
- COLS, 1041: columns per row; column indices 0..COLS-1
- ROWS, 4: rows per frame
- STEP, 1: columns consumed per valid beat; COLS % STEP must be 0
- MF_LEN, 256: frames per multiframe
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high
- i_valid  in  1  one beat of STEP columns present this cycle
- i_sync  in  1  frame alignment: the current beat (or next beat if !i_valid) is column 0, row 0, multiframe 0
- o_col_cnt  out  clog2(COLS)  registered column of the next beat
- o_row_cnt  out  clog2(ROWS)  registered row of the next beat
- o_mf_cnt  out  clog2(MF_LEN)  registered multiframe index of the next beat
- o_sof  out  1  current beat is column 0, row 0
- o_eor  out  1  current beat contains column COLS-1
- o_eof  out  1  current beat contains column COLS-1 of row ROWS-1
- o_locked  out  1  at least one i_sync has been received since reset

## Operation
- Effective position: (col_e, row_e, mf_e) = (0,0,0) if i_sync, else the registered counts.
- Strobes are combinational: o_sof = i_valid & col_e==0 & row_e==0. o_eor = i_valid & col_e==COLS-STEP. o_eof = o_eor & row_e==ROWS-1.
- Update on a valid beat: col_next = col_e+STEP, or 0 when col_e==COLS-STEP.
- On column wrap: row_next = row_e+1, or 0 at ROWS-1.
- On row wrap at ROWS-1: mf_next = mf_e+1, or 0 at MF_LEN-1.
- No valid beat: if i_sync, all counts load 0; otherwise all counts hold.
- o_locked: 0 at reset; set on any cycle with i_sync; stays set until reset. Counting does not depend on o_locked; counts free-run from reset.
- Degenerate cases: COLS==STEP wraps the column every beat; ROWS==1 wraps the row on every column wrap; MF_LEN==1 holds mf at 0.
- Counter widths: clog2 of the modulus, minimum 1 bit. Compare against the constant terminal value, never rely on natural overflow.

## Timing
- Reset (async assert, sync release): o_col_cnt=0, o_row_cnt=0, o_mf_cnt=0, o_locked=0. Strobes follow the input formula, so o_sof=i_valid during reset.
- Counter latency: 1 cycle from a valid beat to the updated counts.
- Strobe latency: 0 cycles; strobes are combinational from i_valid/i_sync and the registers.
- i_sync with i_valid: that beat is (0,0,0), o_sof=1, and the next counts are (STEP mod wrap, 0, 0).
- i_sync at the natural wrap point gives a result identical to no sync; the bench checks this.
- Reset mid-frame: counts return to 0 immediately and o_locked clears. The first post-reset beat is treated as (0,0,0).

## Structure
- Package fpc_pkg: clog2 function and default constants (FPC_COLS=1041, FPC_ROWS=4, FPC_MF_LEN=256).
- Sub-module fpc_wrap_cnt: parametrised modulus/step counter with inputs en, clr, and outputs cnt, wrap. Instantiated three times (col, row, mf) and chained by wrap → en.
- Elaboration-time check: fail the build if COLS % STEP != 0.

## Test plan
- Default parameters, reset then 4164 continuous valid beats:
  - o_eor pulses every 1041 beats.
  - o_eof pulses on beat 4163.
  - Counts return to (0,0) and o_mf_cnt=1 after beat 4163.
- COLS=16, ROWS=2, STEP=4, gapped i_valid (1 in 3):
  - o_col_cnt steps 0,4,8,12,0.
  - Counts hold across idle cycles.
  - o_eor occurs with col_e=12.
- Mid-frame i_sync with i_valid at col 7, row 1:
  - o_sof=1 that cycle.
  - Next counts (1,0,0).
  - o_locked rises next cycle and stays high.
- i_sync without i_valid at col 5: next counts (0,0,0), and the next valid beat gives o_sof=1.
- MF_LEN=4, COLS=4, ROWS=2: after 32 beats o_mf_cnt wraps 3→0 on the eof beat.
- Async i_rst asserted mid-frame with clock stopped: outputs reach 0 immediately. After release, the first valid beat gives o_sof=1.
